ddr3_req_arbiter: RTL and testbench

Round-robin arbiter that shares the single CPU-side command port of the DDR3 memory controller between NREQ independent requesters. It sits between the requesters and the controller's CPU interface. It latches one request at a time, issues it to the controller and waits for completion. It then routes the read data or write acknowledgement back to the winning requester. A watchdog aborts any transaction that the controller fails to complete, so a hung controller cannot lock out the other requesters.

---
 rtl/ddr3_req_arbiter.sv | 157 +++++++++++++++
 tb/tb_ddr3_req_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_req_arbiter.sv
// Round-robin arbiter sharing the DDR3 controller CPU command port between NREQ requesters.
// One transaction in flight at a time; a watchdog aborts commands the controller never completes.
module ddr3_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 27,
    parameter int DW      = 64,
    parameter int TIMEOUT = 1023
) (
    input  logic              i_cpu_ck,
    input  logic              i_cpu_reset,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [NREQ-1:0]   i_req_write,
    input  logic [NREQ*AW-1:0] i_req_addr,
    input  logic [NREQ*DW-1:0] i_req_wdata,
    output logic [NREQ-1:0]   o_req_ready,
    output logic [NREQ-1:0]   o_rsp_valid,
    output logic [DW-1:0]     o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_cmd_valid,
    output logic              o_cmd_write,
    output logic [AW-1:0]     o_cmd_addr,
    output logic [DW-1:0]     o_cmd_wdata,
    input  logic              i_cmd_ready,
    input  logic              i_rd_valid,
    input  logic [DW-1:0]     i_rd_data,
    input  logic              i_wr_done
);

    localparam int PW = $clog2(NREQ);
    localparam int SW = PW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [PW-1:0] LAST_REQ = PW'(NREQ - 1);
    localparam logic [SW-1:0] NREQ_W   = SW'(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   grant;
    logic [PW-1:0]   win_idx;
    logic [SW-1:0]   scan_sum;
    logic            any_valid;
    logic [CW-1:0]   cnt;
    logic            done;
    logic            expired;
    logic [AW-1:0]   req_addr_a  [NREQ];
    logic [DW-1:0]   req_wdata_a [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign req_addr_a[k]  = i_req_addr[k*AW +: AW];
        assign req_wdata_a[k] = i_req_wdata[k*DW +: DW];
    end

    // Scan upward from rr_ptr, wrapping modulo NREQ; the first valid requester wins.
    always_comb begin
        any_valid = 1'b0;
        win_idx   = '0;
        scan_sum  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            scan_sum = {1'b0, rr_ptr} + SW'(i);
            if (scan_sum >= NREQ_W) begin
                scan_sum = scan_sum - NREQ_W;
            end
            if (!any_valid && i_req_valid[scan_sum[PW-1:0]]) begin
                any_valid = 1'b1;
                win_idx   = scan_sum[PW-1:0];
            end
        end
    end

    // Wrong-type completion pulses are ignored by selecting on the latched command type.
    assign done    = o_cmd_write ? i_wr_done : i_rd_valid;
    assign expired = (cnt == CNT_MAX);

    always_ff @(posedge i_cpu_ck) begin
        if (i_cpu_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = ISSUE;
            ISSUE:   if (i_cmd_ready) state_nxt = WAIT;
            WAIT:    if (done || expired) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = '0;
        o_rsp_valid = '0;
        o_cmd_valid = 1'b0;
        case (state)
            IDLE:    if (any_valid && !i_cpu_reset) o_req_ready[win_idx] = 1'b1;
            ISSUE:   o_cmd_valid = 1'b1;
            RESP:    o_rsp_valid[grant] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_cpu_ck) begin
        if (i_cpu_reset) begin
            rr_ptr      <= '0;
            grant       <= '0;
            cnt         <= '0;
            o_cmd_write <= 1'b0;
            o_cmd_addr  <= '0;
            o_cmd_wdata <= '0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant       <= win_idx;
                        o_cmd_write <= i_req_write[win_idx];
                        o_cmd_addr  <= req_addr_a[win_idx];
                        o_cmd_wdata <= req_wdata_a[win_idx];
                    end
                end
                ISSUE: begin
                    if (i_cmd_ready) begin
                        cnt <= '0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // Completion takes priority over a simultaneous watchdog expiry.
                    if (done) begin
                        o_rsp_rdata <= o_cmd_write ? '0 : i_rd_data;
                        o_rsp_err   <= 1'b0;
                    end else if (expired) begin
                        o_rsp_rdata <= '0;
                        o_rsp_err   <= 1'b1;
                    end
                end
                RESP: begin
                    rr_ptr <= (grant == LAST_REQ) ? '0 : grant + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_req_arbiter.sv
// Randomized self-checking bench for ddr3_req_arbiter against a transaction-level model
// that tracks the round-robin pointer and the expected completion/timeout outcome.
module tb_ddr3_req_arbiter;

    localparam int NREQ    = 4;
    localparam int AW      = 27;
    localparam int DW      = 64;
    localparam int TIMEOUT = 15;

    logic               i_cpu_ck = 1'b0;
    logic               i_cpu_reset;
    logic [NREQ-1:0]    i_req_valid;
    logic [NREQ-1:0]    i_req_write;
    logic [NREQ*AW-1:0] i_req_addr;
    logic [NREQ*DW-1:0] i_req_wdata;
    logic [NREQ-1:0]    o_req_ready;
    logic [NREQ-1:0]    o_rsp_valid;
    logic [DW-1:0]      o_rsp_rdata;
    logic               o_rsp_err;
    logic               o_cmd_valid;
    logic               o_cmd_write;
    logic [AW-1:0]      o_cmd_addr;
    logic [DW-1:0]      o_cmd_wdata;
    logic               i_cmd_ready;
    logic               i_rd_valid;
    logic [DW-1:0]      i_rd_data;
    logic               i_wr_done;

    ddr3_req_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_cpu_ck    (i_cpu_ck),
        .i_cpu_reset (i_cpu_reset),
        .i_req_valid (i_req_valid),
        .i_req_write (i_req_write),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .o_req_ready (o_req_ready),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err),
        .o_cmd_valid (o_cmd_valid),
        .o_cmd_write (o_cmd_write),
        .o_cmd_addr  (o_cmd_addr),
        .o_cmd_wdata (o_cmd_wdata),
        .i_cmd_ready (i_cmd_ready),
        .i_rd_valid  (i_rd_valid),
        .i_rd_data   (i_rd_data),
        .i_wr_done   (i_wr_done)
    );

    always #5 i_cpu_ck = ~i_cpu_ck;

    int n_checks = 0;
    int n_errors = 0;
    int exp_ptr  = 0;
    logic [AW-1:0] a_tab [NREQ];
    logic [DW-1:0] d_tab [NREQ];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_cpu_ck);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NREQ; i++) begin
            a_tab[i] = AW'($urandom);
            d_tab[i] = {$urandom, $urandom};
        end
    endtask

    task automatic drive_reqs(input logic [NREQ-1:0] v, input logic [NREQ-1:0] w);
        i_req_valid = v;
        i_req_write = w;
        for (int i = 0; i < NREQ; i++) begin
            i_req_addr[i*AW +: AW]  = a_tab[i];
            i_req_wdata[i*DW +: DW] = d_tab[i];
        end
    endtask

    // Model arbitration: first valid requester at or after the pointer, modulo NREQ.
    function automatic int pick(input logic [NREQ-1:0] v);
        for (int off = 0; off < NREQ; off++) begin
            int k;
            k = (exp_ptr + off) % NREQ;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, o_req_ready, 0);
        check({tag, "_rsp_valid"}, o_rsp_valid, 0);
        check({tag, "_rsp_rdata"}, o_rsp_rdata, 0);
        check({tag, "_rsp_err"},   o_rsp_err,   0);
        check({tag, "_cmd_valid"}, o_cmd_valid, 0);
        check({tag, "_cmd_write"}, o_cmd_write, 0);
        check({tag, "_cmd_addr"},  o_cmd_addr,  0);
        check({tag, "_cmd_wdata"}, o_cmd_wdata, 0);
    endtask

    // Entered 1 time unit after an edge with the DUT in IDLE; returns likewise.
    // cpl_dly counts WAIT cycles before the completion pulse; beyond TIMEOUT means never.
    task automatic do_txn(input logic [NREQ-1:0] v, input logic [NREQ-1:0] w, input int rdy_dly,
                          input int cpl_dly, input logic [DW-1:0] rd_word, input bit noise);
        int g;
        bit is_wr;
        bit cpl_ok;
        int resp_at;
        logic [NREQ-1:0] onehot;
        g = pick(v);
        is_wr = w[g];
        onehot = '0;
        onehot[g] = 1'b1;
        cpl_ok = (cpl_dly <= TIMEOUT);
        resp_at = cpl_ok ? cpl_dly : TIMEOUT;
        drive_reqs(v, w);
        #1;
        check("req_ready", o_req_ready, onehot);
        check("idle_cmd_valid", o_cmd_valid, 0);
        tick();
        i_req_valid[g] = 1'b0;
        for (int c = 0; c <= rdy_dly; c++) begin
            i_cmd_ready = (c == rdy_dly);
            #1;
            check("cmd_valid", o_cmd_valid, 1);
            check("cmd_addr", o_cmd_addr, a_tab[g]);
            check("cmd_write", o_cmd_write, is_wr);
            if (is_wr) check("cmd_wdata", o_cmd_wdata, d_tab[g]);
            check("issue_ready", o_req_ready, 0);
            check("issue_rsp_valid", o_rsp_valid, 0);
            tick();
        end
        i_cmd_ready = 1'b0;
        for (int j = 0; j <= resp_at; j++) begin
            i_rd_valid = 1'b0;
            i_wr_done  = 1'b0;
            i_rd_data  = {$urandom, $urandom};
            if (j == cpl_dly) begin
                if (is_wr) begin
                    i_wr_done = 1'b1;
                end else begin
                    i_rd_valid = 1'b1;
                    i_rd_data  = rd_word;
                end
            end
            if (noise && $urandom_range(0, 2) == 0) begin
                if (is_wr) i_rd_valid = 1'b1;
                else i_wr_done = 1'b1;
            end
            #1;
            check("wait_cmd_valid", o_cmd_valid, 0);
            check("wait_rsp_valid", o_rsp_valid, 0);
            check("wait_ready", o_req_ready, 0);
            tick();
        end
        i_rd_valid = 1'b0;
        i_wr_done  = 1'b0;
        #1;
        check("rsp_valid", o_rsp_valid, onehot);
        check("rsp_err", o_rsp_err, !cpl_ok);
        if (!cpl_ok || !is_wr) check("rsp_rdata", o_rsp_rdata, cpl_ok ? rd_word : 64'h0);
        check("rsp_ready", o_req_ready, 0);
        tick();
        check("post_rsp_valid", o_rsp_valid, 0);
        exp_ptr = (g + 1) % NREQ;
    endtask

    initial begin
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] w;
        int cpl;
        i_cpu_reset = 1'b1;
        i_req_valid = '0;
        i_req_write = '0;
        i_req_addr  = '0;
        i_req_wdata = '0;
        i_cmd_ready = 1'b0;
        i_rd_valid  = 1'b0;
        i_rd_data   = '0;
        i_wr_done   = 1'b0;
        repeat (3) tick();
        i_cpu_reset = 1'b0;
        check_all_zero("reset");
        exp_ptr = 0;

        // Directed read from requester 2.
        fill_random();
        a_tab[2] = 27'h100;
        do_txn(4'b0100, 4'b0000, 0, 3, 64'hDEADBEEF, 0);

        // Controller stalls command acceptance for 20 cycles.
        fill_random();
        do_txn(4'b1011, 4'b1111, 20, 2, 64'h0, 0);
        fill_random();
        do_txn(4'b0110, 4'b0000, 20, 1, {$urandom, $urandom}, 1);

        // Write that never completes, then a normal read.
        fill_random();
        do_txn(4'b0001, 4'b0001, 1, 1000, 64'h0, 1);
        fill_random();
        do_txn(4'b1000, 4'b0000, 0, 0, {$urandom, $urandom}, 0);

        // Completion on the expiry cycle, and one cycle too late.
        fill_random();
        do_txn(4'b0010, 4'b0000, 0, TIMEOUT, 64'h0123_4567_89AB_CDEF, 1);
        fill_random();
        do_txn(4'b0100, 4'b0000, 0, TIMEOUT + 1, 64'hFFFF_0000_FFFF_0000, 0);
        fill_random();
        do_txn(4'b1100, 4'b1111, 2, TIMEOUT, 64'h0, 1);

        // Reset during WAIT drops the transaction and rewinds the pointer.
        fill_random();
        do_txn(4'b0010, 4'b0000, 0, 1, {$urandom, $urandom}, 0);
        fill_random();
        drive_reqs(4'b0100, 4'b0000);
        #1;
        check("rst_txn_ready", o_req_ready, 4'b0100);
        tick();
        i_req_valid = '0;
        i_cmd_ready = 1'b1;
        tick();
        i_cmd_ready = 1'b0;
        repeat (2) tick();
        i_cpu_reset = 1'b1;
        tick();
        i_cpu_reset = 1'b0;
        check_all_zero("midrst");
        exp_ptr = 0;
        i_rd_valid = 1'b1;
        i_rd_data  = {$urandom, $urandom};
        tick();
        i_rd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stray_rsp_valid", o_rsp_valid, 0);
            check("stray_cmd_valid", o_cmd_valid, 0);
            tick();
        end

        // All requesters continuously valid: grants rotate from requester 0.
        for (int i = 0; i < 8; i++) begin
            fill_random();
            do_txn(4'b1111, NREQ'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                   {$urandom, $urandom}, 1);
        end

        for (int i = 0; i < 40; i++) begin
            fill_random();
            v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            w = NREQ'($urandom);
            cpl = ($urandom_range(0, 4) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 3)
                                              : $urandom_range(0, 4);
            do_txn(v, w, $urandom_range(0, 3), cpl, {$urandom, $urandom}, 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
